// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM state type, arm length and vote-counter width helper for the PUF reader
package puf_pkg;
  typedef enum logic [2:0] {IDLE, ARM, EVAL, SAMPLE, FINISH} state_t;
  localparam int ARM_CYCLES = 2;
  function automatic int cnt_width(input int votes);
    return $clog2(votes + 1);
  endfunction
endpackage

// File: rtl/puf_cell.sv
// puf_cell: one-bit ring-latch PUF cell; enable/reset in, settled bit q out (BIAS is the cell's settled value)
module puf_cell #(
  parameter logic BIAS = 1'b0
) (
  input  logic enable,
  input  logic reset,
  output logic q
);
  assign q = enable & ~reset & BIAS;
endmodule

// File: rtl/puf_cell_array.sv
// puf_cell_array: TOTAL kept PUF cells; shared enable/reset (active-high) in, raw[TOTAL-1:0] out
module puf_cell_array #(
  parameter int TOTAL = 128
) (
  input  logic             enable,
  input  logic             reset,
  output logic [TOTAL-1:0] raw
);
  for (genvar g = 0; g < TOTAL; g++) begin : g_cell
    (* keep *) puf_cell #(.BIAS(1'(g % 3 == 1))) u_cell (.enable(enable), .reset(reset), .q(raw[g]));
  end
endmodule

// File: rtl/puf_vote_reader.sv
// puf_vote_reader: handshaked majority-vote PUF word read; clk/reset_n/start/addr in, busy/done/out_word/unstable out
module puf_vote_reader
  import puf_pkg::*;
#(
  parameter int ADDR_BITS     = 4,
  parameter int OUT_BITS      = 8,
  parameter int VOTES         = 5,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_BITS-1:0]  out_word,
  output logic [OUT_BITS-1:0]  unstable
);
  localparam int TOTAL = (2 ** ADDR_BITS) * OUT_BITS;
  localparam int CW    = cnt_width(VOTES);
  localparam int TW    = $clog2(SETTLE_CYCLES + ARM_CYCLES);
  localparam int BW    = $clog2(TOTAL);
  if (VOTES < 1 || VOTES % 2 == 0) begin : g_bad_votes
    $error("VOTES must be odd and at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  state_t                      state, nxt;
  logic [TW-1:0]               timer;
  logic [CW-1:0]               rounds;
  logic [ADDR_BITS-1:0]        addr_q;
  logic [OUT_BITS-1:0]         sync1, sync2, word, maj, unst;
  logic [OUT_BITS-1:0][CW-1:0] cnt, cnt_nx;
  logic [BW-1:0]               base_idx;
  logic [TOTAL-1:0]            raw;
  logic                        arr_en, arr_rst;
  puf_cell_array #(.TOTAL(TOTAL)) u_array (.enable(arr_en), .reset(arr_rst), .raw(raw));
  assign base_idx = BW'(addr_q) * BW'(OUT_BITS);
  assign word     = raw[base_idx +: OUT_BITS];
  always_comb begin
    nxt     = state;
    busy    = state inside {ARM, EVAL, SAMPLE};
    done    = state == FINISH;
    arr_en  = state == EVAL;
    arr_rst = state != EVAL;
    case (state)
      IDLE:    nxt = start ? ARM : IDLE;
      ARM:     nxt = timer == TW'(ARM_CYCLES - 1) ? EVAL : ARM;
      EVAL:    nxt = timer == TW'(SETTLE_CYCLES - 1) ? SAMPLE : EVAL;
      SAMPLE:  nxt = rounds == CW'(VOTES - 1) ? FINISH : ARM;
      default: nxt = IDLE;
    endcase
  end
  // sync2 in SAMPLE holds the word captured one edge before EVAL ended
  always_comb begin
    cnt_nx = cnt;
    maj    = '0;
    unst   = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      cnt_nx[i] = cnt[i] + CW'(sync2[i]);
      maj[i]    = cnt_nx[i] > CW'(VOTES / 2);
      unst[i]   = cnt_nx[i] != '0 && cnt_nx[i] != CW'(VOTES);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      rounds   <= '0;
      addr_q   <= '0;
      sync1    <= '0;
      sync2    <= '0;
      cnt      <= '0;
      out_word <= '0;
      unstable <= '0;
    end else begin
      state <= nxt;
      timer <= nxt == state ? timer + 1'b1 : '0;
      sync1 <= word;
      sync2 <= sync1;
      if (state == IDLE && start) begin
        addr_q <= addr;
        rounds <= '0;
        cnt    <= '0;
      end
      if (state == SAMPLE) begin
        rounds <= rounds + 1'b1;
        cnt    <= cnt_nx;
      end
      if (state == SAMPLE && nxt == FINISH) begin
        out_word <= maj;
        unstable <= unst;
      end
    end
  end
endmodule

// File: tb/tb_puf_vote_reader.sv
// tb_puf_vote_reader: randomized self-checking bench with a per-round behavioural model of the cell array
module tb_puf_vote_reader;
  localparam int LAT = 5 * (16 + 3);
  logic clk = 0, reset_n = 0, start = 0, start2 = 0;
  logic [3:0] addr = '0;
  logic [1:0] addr2 = '0;
  logic busy, done, busy2, done2;
  logic [7:0] out_word, unstable;
  logic [1:0] out2, unst2;
  int ncmp = 0, nfail = 0;
  logic [127:0] pat [10];
  int nfall = 0, base = 0, idx;
  logic [127:0] ra;
  logic [7:0] rb = '0;
  always #5 clk = ~clk;
  puf_vote_reader dut (.clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .busy(busy), .done(done), .out_word(out_word), .unstable(unstable));
  puf_vote_reader #(.ADDR_BITS(2), .OUT_BITS(2), .VOTES(1), .SETTLE_CYCLES(1)) dut2 (.clk(clk), .reset_n(reset_n), .start(start2), .addr(addr2), .busy(busy2), .done(done2), .out_word(out2), .unstable(unst2));
  always @(negedge dut.u_array.enable) nfall++;
  always_comb begin
    idx = nfall - base;
    ra  = pat[idx < 0 ? 0 : (idx > 9 ? 9 : idx)];
  end
  always @(ra) force dut.raw = ra;
  always @(rb) force dut2.raw = rb;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [15:0] ref_read(input int a, input int r0);
    logic [7:0] o, u;
    int c;
    for (int i = 0; i < 8; i++) begin
      c = 0;
      for (int r = 0; r < 5; r++) c += int'(pat[r0 + r][a * 8 + i]);
      o[i] = c > 5 / 2;
      u[i] = c != 0 && c != 5;
    end
    return {u, o};
  endfunction
  task automatic noisy_pats(input int n);
    logic [127:0] w;
    w = rand128();
    for (int r = 0; r < n; r++) pat[r] = w ^ (rand128() & rand128() & rand128());
  endtask
  task automatic start_read(input int a);
    base = nfall;
    addr = 4'(a);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", 32'(busy), 1);
  endtask
  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
  endtask
  initial begin
    int k, k1, k2, nd, a;
    logic [15:0] o1, o2;
    for (int r = 0; r < 10; r++) pat[r] = '0;
    #1;
    force dut.raw = ra;
    force dut2.raw = rb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out", 32'(out_word), 0);
    chk("rst_unst", 32'(unstable), 0);
    chk("rst_arr_reset", 32'(dut.u_array.reset), 1);
    chk("rst_arr_en", 32'(dut.u_array.enable), 0);
    reset_n = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 5; r++) begin
      pat[r] = rand128();
      pat[r][3 * 8 +: 8] = 8'hA5;
    end
    start_read(3);
    wait_done(k);
    chk("stable_latency", 32'(k), LAT);
    chk("stable_out", 32'(out_word), 32'hA5);
    chk("stable_unst", 32'(unstable), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("out_hold", 32'(out_word), 32'hA5);
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 10; r++) pat[r] = '0;
      for (int r = 0; r < 5; r++) pat[r][7 * 8] = p == 0 ? 1'((22 >> (4 - r)) & 1) : 1'(r == 3);
      start_read(7);
      wait_done(k);
      chk("maj_latency", 32'(k), LAT);
      chk("maj_result", 32'({unstable, out_word}), 32'(ref_read(7, 0)));
      chk("maj_out_const", 32'(out_word), p == 0 ? 32'h01 : 32'h00);
      chk("maj_unst_const", 32'(unstable), 32'h01);
      @(posedge clk); #1;
    end
    for (int t = 0; t < 6; t++) begin
      a = $urandom_range(0, 15);
      noisy_pats(5);
      start_read(a);
      wait_done(k);
      chk("rand_latency", 32'(k), LAT);
      chk("rand_result", 32'({unstable, out_word}), 32'(ref_read(a, 0)));
      @(posedge clk); #1;
    end
    noisy_pats(5);
    start_read(3);
    nd = 0;
    k1 = -1;
    o1 = '0;
    for (int j = 1; j <= 250; j++) begin
      if (j == 9) begin start = 1; addr = 4'd5; end
      if (j == 10) start = 0;
      if (j == 30) addr = 4'd12;
      @(posedge clk); #1;
      if (done) begin nd++; k1 = j; o1 = {unstable, out_word}; end
    end
    chk("busy_ignore_ndone", 32'(nd), 1);
    chk("busy_ignore_latency", 32'(k1), LAT);
    chk("busy_ignore_result", 32'(o1), 32'(ref_read(3, 0)));
    noisy_pats(10);
    for (int r = 5; r < 10; r++) pat[r] = rand128() ^ (rand128() & rand128());
    base = nfall;
    addr = 4'd0;
    start = 1;
    @(posedge clk); #1;
    k1 = -1;
    k2 = -1;
    for (int j = 1; j <= 260 && k2 < 0; j++) begin
      @(posedge clk); #1;
      if (done) begin
        if (k1 < 0) begin k1 = j; o1 = {unstable, out_word}; addr = 4'd15; end
        else begin k2 = j; o2 = {unstable, out_word}; start = 0; end
      end
    end
    start = 0;
    chk("b2b_first_latency", 32'(k1), LAT);
    chk("b2b_second_latency", 32'(k2), 2 * LAT + 2);
    chk("b2b_first_result", 32'(o1), 32'(ref_read(0, 0)));
    chk("b2b_second_result", 32'(o2), 32'(ref_read(15, 5)));
    repeat (2) @(posedge clk);
    #1;
    noisy_pats(5);
    start_read($urandom_range(0, 15));
    repeat (25) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(busy), 1);
    reset_n = 0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_out", 32'(out_word), 0);
    chk("abort_unst", 32'(unstable), 0);
    chk("abort_arr_reset", 32'(dut.u_array.reset), 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    nd = 0;
    for (int j = 0; j < 150; j++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 0);
    for (int t = 0; t < 4; t++) begin
      rb = 8'($urandom);
      addr2 = 2'(t == 0 ? 2 : $urandom_range(0, 3));
      start2 = 1;
      @(posedge clk); #1;
      start2 = 0;
      k = 0;
      while (done2 !== 1'b1 && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      chk("sweep_latency", 32'(k), 4);
      chk("sweep_out", 32'(out2), 32'(rb[addr2 * 2 +: 2]));
      chk("sweep_unst", 32'(unst2), 0);
      @(posedge clk); #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/puf_vote_reader.md
# puf_vote_reader

Parametrised PUF readout block: owns a 2**ADDR_BITS x OUT_BITS array of one-bit ring-latch PUF cells and a controller FSM. On a start request it runs VOTES arm/evaluate/sample rounds on the addressed word and returns the per-bit majority result with a per-bit instability mask. It sits between the chip I/O wrapper and the PUF cells, and replaces the free-running single-sample readout with a deterministic, handshaked, noise-filtered read.

## Interface
- ADDR_BITS, 4: word address width; the array holds 2**ADDR_BITS words.
- OUT_BITS, 8: bits per word and width of the result.
- VOTES, 5: evaluation rounds per read. Must be odd and at least 1; elaboration fails otherwise.
- SETTLE_CYCLES, 16: cycles the array is enabled before each sample. Must be at least 1.
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  read request; sampled only in IDLE.
- addr  in  ADDR_BITS  word address; captured on the accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when out_word and unstable are updated.
- out_word  out  OUT_BITS  majority value per bit of the addressed word.
- unstable  out  OUT_BITS  bit = 1 when that bit's votes were not unanimous.

## Operation
- Reset (reset_n = 0, asynchronous): FSM goes to IDLE; busy, done, out_word, unstable = 0; vote counters = 0; array held with cell reset = 1 and cell enable = 0.
- States: IDLE -> ARM -> EVAL -> SAMPLE -> (ARM or FINISH) -> IDLE.
- IDLE:
  - Array held in reset (reset = 1, enable = 0).
  - On start = 1: latch addr, clear vote counters and the round counter, go to ARM.
- ARM (2 cycles): reset = 1, enable = 0; all cell latches are discharged.
- EVAL (SETTLE_CYCLES cycles): reset = 0, enable = 1; the cells race and settle.
- SAMPLE (1 cycle):
  - Register the addressed word, raw[addr*OUT_BITS +: OUT_BITS], through a 2-flop synchroniser captured at the end of EVAL.
  - Add each bit to its counter; each counter is $clog2(VOTES+1) bits wide.
  - Increment the round counter. Go to ARM if rounds < VOTES, otherwise go to FINISH.
- FINISH (1 cycle):
  - out_word[i] = (count[i] > VOTES/2).
  - unstable[i] = (count[i] != 0) && (count[i] != VOTES).
  - done = 1, busy = 0. Next state is IDLE.
- Outputs hold their last values until the next FINISH or reset.
- start while busy: ignored, not queued.
- start asserted in the IDLE cycle right after done: accepted; back-to-back reads are legal.
- addr changes while busy: no effect.
- reset_n asserted mid-read: the read is aborted and no done pulse is issued.

## Timing
- Start is accepted at clock edge T0; busy is high from T0+1.
- One round takes SETTLE_CYCLES + 3 cycles.
- done is high during cycle T0 + VOTES*(SETTLE_CYCLES+3) + 1, which is cycle 96 with the defaults. out_word and unstable are valid in that same cycle.
- The addressed raw bits must be stable for 2 clk cycles before the end of EVAL. SETTLE_CYCLES must cover this in silicon.

## Structure
- Shared package puf_pkg holds:
  - The state enum: IDLE, ARM, EVAL, SAMPLE, FINISH.
  - The ARM_CYCLES = 2 constant.
  - The vote-counter width function.
- Sub-module puf_cell_array:
  - Parameter TOTAL = 2**ADDR_BITS*OUT_BITS.
  - Ports: enable, reset (active-high, to the cells), raw[TOTAL-1:0].
  - Instantiates the existing one-bit cell TOTAL times, each with keep attributes.
  - The bench substitutes a behavioural puf_cell_array with the same ports. The real cells oscillate in zero-delay simulation.

## Test plan
- Reset: drive reset_n = 0 mid-EVAL of an active read -> busy = done = out_word = unstable = 0 immediately. Array reset = 1. No done pulse after release.
- Stable read: model word 3 = 0xA5 on every round, start with addr = 3 -> done at T0+96, out_word = 0xA5, unstable = 0x00.
- Majority: model bit 0 of word 7 gives 1,0,1,1,0 over the five rounds (others 0) -> out_word = 0x01, unstable = 0x01. Pattern 0,0,0,1,0 -> out_word = 0x00, unstable = 0x01.
- Ignore during busy: second start with addr = 5 at T0+10 -> exactly one done pulse, result from addr 3. addr change during EVAL -> no effect.
- Back-to-back: start held high continuously, addr 0 then 15 -> dones at T0+96 and T0+193. Result of the second read = model word 15 (the last address, 2**ADDR_BITS-1).
- Parameter sweep: ADDR_BITS = 2, OUT_BITS = 2, VOTES = 1, SETTLE_CYCLES = 1 -> latency 5. unstable is always 0. Read of addr 2 returns raw[5:4].
